// File: rtl/if_scratch_writer_if.sv
// rtl/if_scratch_writer_if.sv - input-feature stream handshake bundle
//
// Purpose : groups the input-feature stream (word, valid, last, ready)
//           into one port for the scratchpad writer.
// Signals : tdata  - one scratchpad cell worth of feature data
//           tvalid - tdata/tlast are present
//           tlast  - current word is the final word of the stream
//           tready - sink accepts the word on an edge with tvalid && tready
// Modports: master - stream producer, slave - scratchpad writer

interface if_scratch_writer_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/if_scratch_writer.sv
// rtl/if_scratch_writer.sv - input-feature scratchpad write stage
//
// Purpose : writes an input-feature stream into a CELL_NUMS_IF-deep circular
//           scratchpad, advancing write_cnt_if for the window/stride checker
//           and stalling when the next write would hit write_start.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           start        - one-cycle pulse, restarts the fill at cell 0
//           s_in         - input stream (slave side of the handshake bundle)
//           write_start  - oldest cell still needed by the checker
//           read_addr    - datapath read address
//           read_data    - combinational read of the addressed cell
//           write_cnt_if - next cell to be written
//           full         - next write would overrun write_start
//           fill_count   - words accepted since start, saturating
//           stream_done  - final word accepted, held until next start

module if_scratch_writer #(
    parameter int IF_CELL_SIZE    = 8,
    parameter int IF_ADDRESS_SIZE = 8,
    parameter int CELL_NUMS_IF    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    if_scratch_writer_if.slave         s_in,
    input  logic [IF_ADDRESS_SIZE:0]   write_start,
    input  logic [IF_ADDRESS_SIZE:0]   read_addr,
    output logic [IF_CELL_SIZE-1:0]    read_data,
    output logic [IF_ADDRESS_SIZE-1:0] write_cnt_if,
    output logic                       full,
    output logic [IF_ADDRESS_SIZE:0]   fill_count,
    output logic                       stream_done
);

    localparam int IDX_W = (CELL_NUMS_IF > 1) ? $clog2(CELL_NUMS_IF) : 1;
    localparam logic [IF_ADDRESS_SIZE:0]   DEPTH_W  = (IF_ADDRESS_SIZE+1)'(CELL_NUMS_IF);
    localparam logic [IF_ADDRESS_SIZE-1:0] LAST_IDX = IF_ADDRESS_SIZE'(CELL_NUMS_IF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [IF_ADDRESS_SIZE-1:0]  wcnt_q, wcnt_d;
    logic [IF_ADDRESS_SIZE:0]    fcnt_q, fcnt_d;
    logic                        done_q, done_d;
    logic [IF_CELL_SIZE-1:0]     mem_q [CELL_NUMS_IF];

    logic [IF_ADDRESS_SIZE-1:0]  wcnt_inc;
    logic [IF_ADDRESS_SIZE-1:0]  ws_mod;
    logic [IF_ADDRESS_SIZE-1:0]  rd_mod;
    logic                        full_w;
    logic                        ready_w;
    logic                        accept;
    logic                        wr_en;

    // Boundary and read addresses carry one extra bit; only their position
    // inside the ring matters. The result is always below the depth, so the
    // narrowing cast never discards set bits.
    function automatic logic [IF_ADDRESS_SIZE-1:0] ring_pos(input logic [IF_ADDRESS_SIZE:0] v);
        return IF_ADDRESS_SIZE'(v % DEPTH_W);
    endfunction

    // Wrap by compare so a non power-of-two depth still steps last -> 0.
    assign wcnt_inc = (wcnt_q == LAST_IDX) ? '0 : wcnt_q + 1'b1;
    assign ws_mod   = ring_pos(write_start);
    assign rd_mod   = ring_pos(read_addr);

    // Same condition the checker uses for its write-enable: one cell is
    // always kept empty so full and empty stay distinguishable.
    assign full_w   = (wcnt_inc == ws_mod);

    // start masks ready so a word is never accepted in the cycle that
    // rewinds the pointer (it would land at the old pointer and be lost).
    assign ready_w  = (state_q == ST_FILL) && !full_w && !start;
    assign accept   = s_in.tvalid && ready_w;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        fcnt_d  = fcnt_q;
        done_d  = done_q;
        wr_en   = 1'b0;
        if (start) begin
            state_d = ST_FILL;
            wcnt_d  = '0;
            fcnt_d  = '0;
            done_d  = 1'b0;
        end else if (accept) begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_inc;
            if (fcnt_q != '1) begin
                fcnt_d = fcnt_q + 1'b1;
            end
            if (s_in.tlast) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < CELL_NUMS_IF; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
            if (wr_en) begin
                mem_q[IDX_W'(wcnt_q)] <= s_in.tdata;
            end
        end
    end

    assign s_in.tready  = ready_w;
    assign full         = full_w;
    assign write_cnt_if = wcnt_q;
    assign fill_count   = fcnt_q;
    assign stream_done  = done_q;
    assign read_data    = mem_q[IDX_W'(rd_mod)];

endmodule
